// File: rtl/sar_seq_ctrl.sv
// SAR conversion sequencer: walks a one-hot mask over the DAC word on each comparator
// strobe, optionally collects residue decisions, and hands the result off with ready/valid.
module sar_seq_ctrl #(
   parameter int NDAC   = 16,
   parameter int NEXTRA = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [NDAC-1:0]   dac_astate,
   input  logic [NDAC-1:0]   dac_bstate,
   input  logic              comp,
   input  logic              comp_valid,
   output logic [NDAC-1:0]   dac_state,
   output logic              busy,
   output logic [NDAC-1:0]   res_data,
   output logic [NEXTRA-1:0] res_extra,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int CW = (NEXTRA > 1) ? $clog2(NEXTRA) : 1;
   localparam logic [1:0] M_STATIC = 2'b00;
   localparam logic [1:0] M_SAR    = 2'b01;
   localparam logic [1:0] M_EXTRA  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_EXTRA} state_t;

   state_t            state_q, state_d;
   logic [NDAC-1:0]   dac_state_q, dac_state_d;
   logic [NDAC-1:0]   mask_q, mask_d;
   logic [1:0]        mode_q, mode_d;
   logic [CW-1:0]     extra_cnt_q, extra_cnt_d;
   logic [NEXTRA-1:0] extra_bits_q, extra_bits_d;
   logic [NDAC-1:0]   res_data_q, res_data_d;
   logic [NEXTRA-1:0] res_extra_q, res_extra_d;
   logic              res_valid_q, res_valid_d;
   logic              overrun_q, overrun_d;
   logic              load_res;

   always_comb begin
      state_d      = state_q;
      dac_state_d  = dac_state_q;
      mask_d       = mask_q;
      mode_d       = mode_q;
      extra_cnt_d  = extra_cnt_q;
      extra_bits_d = extra_bits_q;
      res_data_d   = res_data_q;
      res_extra_d  = res_extra_q;
      res_valid_d  = res_valid_q;
      overrun_d    = overrun_q;
      load_res     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d      = S_CONV;
               dac_state_d  = dac_astate;
               mask_d       = {1'b1, {(NDAC-1){1'b0}}};
               mode_d       = (mode == 2'b11) ? M_SAR : mode;
               extra_cnt_d  = '0;
               extra_bits_d = '0;
            end
         end
         S_CONV: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (comp_valid) begin
               if (mode_q == M_STATIC)
                  dac_state_d = dac_bstate;
               else
                  dac_state_d = (dac_state_q & ~mask_q) | (mask_q & {NDAC{comp}});
               mask_d = mask_q >> 1;
               if (mask_q[0]) begin
                  if (mode_q == M_EXTRA) begin
                     state_d = S_EXTRA;
                  end else begin
                     state_d     = S_IDLE;
                     load_res    = 1'b1;
                     res_data_d  = dac_state_d;
                     res_extra_d = '0;
                  end
               end
            end
         end
         S_EXTRA: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (comp_valid) begin
               // Residue decisions fill the extra word MSB first
               for (int i = 0; i < NEXTRA; i++)
                  if (i == NEXTRA - 1 - int'(extra_cnt_q))
                     extra_bits_d[i] = comp;
               extra_cnt_d = extra_cnt_q + CW'(1);
               if (int'(extra_cnt_q) == NEXTRA - 1) begin
                  state_d     = S_IDLE;
                  load_res    = 1'b1;
                  res_data_d  = dac_state_q;
                  res_extra_d = extra_bits_d;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_res)
         res_valid_d = 1'b1;
      else if (res_valid_q && res_ready)
         res_valid_d = 1'b0;

      // A lost result outranks a clear on the same edge
      if (overrun_clr)
         overrun_d = 1'b0;
      if (load_res && res_valid_q && !res_ready)
         overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dac_state_q  <= '0;
         mask_q       <= '0;
         mode_q       <= '0;
         extra_cnt_q  <= '0;
         extra_bits_q <= '0;
         res_data_q   <= '0;
         res_extra_q  <= '0;
         res_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dac_state_q  <= dac_state_d;
         mask_q       <= mask_d;
         mode_q       <= mode_d;
         extra_cnt_q  <= extra_cnt_d;
         extra_bits_q <= extra_bits_d;
         res_data_q   <= res_data_d;
         res_extra_q  <= res_extra_d;
         res_valid_q  <= res_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dac_state = dac_state_q;
   assign busy      = (state_q != S_IDLE);
   assign res_data  = res_data_q;
   assign res_extra = res_extra_q;
   assign res_valid = res_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Bench for sar_seq_ctrl: directed scenarios followed by randomized conversions, all checked
// against a conversion-level reference model (expected words computed from decision lists).
module tb_sar_seq_ctrl;
   localparam int NDAC   = 4;
   localparam int NEXTRA = 2;
   localparam int NW     = NDAC + NEXTRA;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0, abort = 1'b0;
   logic [1:0]        mode = '0;
   logic [NDAC-1:0]   dac_astate = '0, dac_bstate = '0;
   logic              comp = 1'b0, comp_valid = 1'b0;
   logic [NDAC-1:0]   dac_state;
   logic              busy;
   logic [NDAC-1:0]   res_data;
   logic [NEXTRA-1:0] res_extra;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic              overrun;
   logic              overrun_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   logic        exp_rv  = 1'b0;
   logic        exp_ovr = 1'b0;
   logic [31:0] exp_data = '0;
   logic [31:0] exp_extra = '0;

   sar_seq_ctrl #(.NDAC(NDAC), .NEXTRA(NEXTRA)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .dac_astate(dac_astate), .dac_bstate(dac_bstate), .comp(comp), .comp_valid(comp_valid),
      .dac_state(dac_state), .busy(busy), .res_data(res_data), .res_extra(res_extra),
      .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag);
      check({tag, "_rv"},   32'(res_valid), 32'(exp_rv));
      check({tag, "_ovr"},  32'(overrun),   32'(exp_ovr));
      check({tag, "_data"}, 32'(res_data),  exp_data);
      check({tag, "_xtra"}, 32'(res_extra), exp_extra);
   endtask

   // One conversion. cw lists the decisions MSB first: NDAC SAR decisions then NEXTRA residue ones.
   task automatic conv(input logic [1:0] m, input logic [NDAC-1:0] a, input logic [NDAC-1:0] b,
                       input logic [NW-1:0] cw, input int abort_at, input bit rdy_f,
                       input bit clr_f, input bit rnd);
      int em, total, sh;
      logic [31:0] exp_dac, lowmask;
      em    = (m == 2'b11) ? 1 : int'(m);
      total = (em == 2) ? NW : NDAC;
      start = 1'b1; mode = m; dac_astate = a;
      comp_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      comp = 1'($urandom);
      tick();
      start = 1'b0; comp_valid = 1'b0;
      exp_dac = 32'(a);
      check("start_dac",  32'(dac_state), exp_dac);
      check("start_busy", 32'(busy), 32'd1);
      for (int k = 0; k < total; k++) begin
         if (rnd) begin
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
               comp = 1'($urandom); mode = 2'($urandom);
               dac_astate = NDAC'($urandom); start = 1'($urandom);
               tick();
               start = 1'b0;
               check("gap_dac",  32'(dac_state), exp_dac);
               check("gap_busy", 32'(busy), 32'd1);
            end
         end
         if (k == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_dac",  32'(dac_state), exp_dac);
            check("abort_rv",   32'(res_valid), 32'(exp_rv));
            $display("[TB] conv mode=%0d astate=%h aborted before strobe %0d", m, a, k);
            return;
         end
         comp = cw[NW-1-k];
         comp_valid = 1'b1;
         dac_bstate = rnd ? NDAC'($urandom) : b;
         if (k == total - 1) begin
            res_ready = rdy_f; overrun_clr = clr_f;
         end
         if (k < NDAC) begin
            if (em == 0) begin
               exp_dac = 32'(dac_bstate);
            end else begin
               // Top k+1 bits come from decisions, the rest still from the initial state
               sh = NDAC - 1 - k;
               lowmask = (32'd1 << sh) - 32'd1;
               exp_dac = ((32'(cw) >> (NEXTRA + sh)) << sh) | (32'(a) & lowmask);
            end
         end
         tick();
         comp_valid = 1'b0;
         check("strobe_dac", 32'(dac_state), exp_dac);
         if (k == total - 1) begin
            if (exp_rv && !rdy_f) exp_ovr = 1'b1;
            else if (clr_f)       exp_ovr = 1'b0;
            exp_rv    = 1'b1;
            exp_data  = exp_dac;
            exp_extra = (em == 2) ? 32'(cw[NEXTRA-1:0]) : 32'd0;
            res_ready = 1'b0; overrun_clr = 1'b0;
            check("done_busy", 32'(busy), 32'd0);
            check_result("done");
            $display("[TB] conv mode=%0d astate=%h res=%h extra=%h ovr=%0d",
                     m, a, res_data, res_extra, overrun);
         end else begin
            check("mid_busy", 32'(busy), 32'd1);
            check("mid_rv",   32'(res_valid), 32'(exp_rv));
         end
      end
   endtask

   task automatic drain();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      exp_rv = 1'b0;
      check_result("drain");
   endtask

   task automatic clear_ovr();
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      check_result("clr");
   endtask

   initial begin
      #2;
      check("rst_dac",  32'(dac_state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_result("rst");
      tick();
      rst_n = 1'b1;
      tick();

      // 1: SAR
      conv(2'b01, 4'b1000, 4'b0000, 6'b1011_00, -1, 1'b0, 1'b0, 1'b0);
      drain();
      // 2: STATIC
      conv(2'b00, 4'b1111, 4'b0101, 6'b0110_00, -1, 1'b0, 1'b0, 1'b0);
      drain();
      // 3: SAR+EXTRA
      conv(2'b10, 4'b0000, 4'b0000, 6'b1100_10, -1, 1'b0, 1'b0, 1'b0);
      drain();
      // 4: overrun, then clear, then accept; mode 11 behaves as SAR
      conv(2'b01, 4'b0011, 4'b0000, 6'b0110_00, -1, 1'b0, 1'b0, 1'b0);
      conv(2'b11, 4'b0011, 4'b0000, 6'b1001_00, -1, 1'b0, 1'b0, 1'b0);
      clear_ovr();
      drain();
      // Load coinciding with accept: stays valid, no overrun; clear loses to a new overrun
      conv(2'b01, 4'b0000, 4'b0000, 6'b0001_00, -1, 1'b0, 1'b0, 1'b0);
      conv(2'b01, 4'b0000, 4'b0000, 6'b1110_00, -1, 1'b1, 1'b0, 1'b0);
      conv(2'b01, 4'b0000, 4'b0000, 6'b0101_00, -1, 1'b0, 1'b1, 1'b0);
      clear_ovr();
      drain();
      // 5: abort after two strobes, then restart
      conv(2'b01, 4'b0110, 4'b0000, 6'b1011_00, 2, 1'b0, 1'b0, 1'b0);
      conv(2'b01, 4'b0110, 4'b0000, 6'b0011_00, -1, 1'b0, 1'b0, 1'b0);
      drain();

      // 6: asynchronous reset in EXTRA, then start+abort in IDLE
      start = 1'b1; mode = 2'b10; dac_astate = 4'b0101;
      tick();
      start = 1'b0;
      for (int k = 0; k < NDAC + 1; k++) begin
         comp = 1'b1; comp_valid = 1'b1;
         tick();
      end
      comp_valid = 1'b0;
      check("extra_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      exp_rv = 1'b0; exp_ovr = 1'b0; exp_data = '0; exp_extra = '0;
      check("arst_dac",  32'(dac_state), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check_result("arst");
      tick();
      rst_n = 1'b1;
      start = 1'b1; abort = 1'b1; dac_astate = 4'b1111;
      tick();
      start = 1'b0; abort = 1'b0;
      check("sa_busy", 32'(busy), 32'd0);
      check("sa_dac",  32'(dac_state), 32'd0);
      tick();
      check("sa_busy2", 32'(busy), 32'd0);
      $display("[TB] reset and start+abort scenario done");

      // Randomized conversions
      for (int t = 0; t < 60; t++) begin
         logic [1:0] m;
         int tot, ab;
         m   = 2'($urandom);
         tot = (m == 2'b10) ? NW : NDAC;
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
         conv(m, NDAC'($urandom), '0, NW'($urandom), ab,
              1'($urandom), 1'($urandom), 1'b1);
         case ($urandom_range(0, 3))
            0: drain();
            1: clear_ovr();
            default: ;
         endcase
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
